wb_mem_arbiter: RTL and testbench
=================================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of Wishbone masters sharing the main RAM slave (instruction, data, debug).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, cycles without slave response before an error is forced; 0 disables the timeout.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports named as follows:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have the following master-side ports:
- m_adr_i  in  NUM_MASTERS*AW  packed master addresses; master 0 in the LSBs.
- m_dat_i  in  NUM_MASTERS*DW  packed write data.
- m_sel_i  in  NUM_MASTERS*(DW/8)  packed byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master strobes.
- m_cti_i  in  NUM_MASTERS*3  packed cycle type.
- m_bte_i  in  NUM_MASTERS*2  packed burst type.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master terminations.
REQ-007 SHALL have the following slave-side and status ports:
- s_adr_o  out  AW.
- s_dat_o  out  DW.
- s_sel_o  out  DW/8.
- s_we_o, s_cyc_o, s_stb_o  out  1 each.
- s_cti_o  out  3.
- s_bte_o  out  2.
- s_dat_i  in  DW.
- s_ack_i, s_err_i, s_rty_i  in  1 each.
- grant_o  out  NUM_MASTERS  one-hot current grant; all zero when idle.

Function
REQ-008 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-009 In IDLE with any m_cyc_i high, SHALL register a grant to the first requester at or after the round-robin pointer (ascending index, wrapping) and enter BUSY on the next edge, giving a one-cycle arbitration latency.
REQ-010 In BUSY, s_adr/dat/sel/we/cti/bte_o SHALL combinationally mux the granted master; s_cyc_o = 1; s_stb_o = granted m_stb_i.
REQ-011 In BUSY, s_ack/err/rty_i SHALL route only to the granted master's m_*_o bit; all other masters' terminations SHALL be 0; m_dat_o = s_dat_i always.
REQ-012 The grant SHALL persist while the granted m_cyc_i stays high, so bursts (cti 3'b010) and back-to-back transfers are never split.
REQ-013 When the granted m_cyc_i is sampled low, SHALL set the pointer to (granted index + 1) mod NUM_MASTERS, clear grant_o, and return to IDLE.
REQ-014 The cycle after a release SHALL be IDLE with s_cyc_o = 0 and s_stb_o = 0; the next grant SHALL appear one cycle later.
REQ-015 In IDLE, all s_* outputs and all m_ack/err/rty_o SHALL be 0.
REQ-016 A requester whose m_cyc_i drops before being granted SHALL be skipped.
REQ-017 An ack in the same cycle the granted master drops cyc SHALL still be delivered; release SHALL follow at the next edge.
REQ-018 Watchdog counter width SHALL be clog2(TIMEOUT+1).
REQ-019 The watchdog counter SHALL increment each BUSY cycle with s_stb_o = 1 and no s_ack/err/rty_i, and SHALL clear otherwise.
REQ-020 When the counter reaches TIMEOUT, SHALL assert m_err_o to the granted master for exactly one cycle, force s_stb_o = 0 in that cycle, and clear the counter.
REQ-021 A slave response coinciding with the timeout cycle SHALL take precedence over the forced error, and no error SHALL be issued.

Reset
REQ-022 Asserting wb_rst_i SHALL asynchronously force IDLE, pointer = 0, grant_o = 0, watchdog counter = 0, s_cyc_o = s_stb_o = 0, and all m_ack/err/rty_o = 0.
REQ-023 Reset asserted mid-burst SHALL abort the transfer silently, with no termination delivered to any master.
REQ-024 After reset deassertion, the first arbitration SHALL give master 0 highest priority.

Structure
REQ-025 State encodings (IDLE = 0, BUSY = 1) and the cti/bte constants SHALL live in the shared Wishbone package/header.
REQ-026 The round-robin picker SHALL be one combinational sub-module, wb_arb_rr_pick, with inputs request vector and pointer and output one-hot pick.

Verification
REQ-027 All masters idle, then m_cyc_i = 3'b011 simultaneously after reset -> grant_o = 001 one cycle later; after m0 releases, one idle cycle, then grant_o = 010.
REQ-028 m0 issues a 4-beat burst (cti 010,010,010,111) while m2 requests -> grant_o stays 001 for all 4 acks; m2 is granted only after m0 drops cyc.
REQ-029 m2 granted, then all three request continuously -> grant order m0, m1, m2, m0 (pointer wraps).
REQ-030 TIMEOUT = 4, slave never acks m1 -> m_err_o = 010 exactly on the 4th stalled cycle; s_stb_o = 0 in that cycle; m0 and m2 see no termination.
REQ-031 wb_rst_i pulsed during beat 2 of an m1 burst -> s_cyc_o = 0 and grant_o = 0 immediately (asynchronously); the next request from m0 and m1 is granted to m0.
REQ-032 s_ack_i returned in the same cycle m0 drops m_cyc_i -> m_ack_o[0] = 1 in that cycle; IDLE on the next edge; pointer = 1.

Source files
------------

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared Wishbone definitions for the main-RAM arbiter: FSM states and
// registered-feedback cycle/burst type codes.
package wb_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_mem_arbiter_rr_pick.sv
// Round-robin picker: one-hot selection of the first requester at or above
// the pointer, wrapping to the lowest requester when none is found there.
module wb_arb_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic [N-1:0] ge_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] cand;

  // Requests at or above the pointer win; otherwise wrap to the full vector.
  assign ge_mask = ~((N'(1) << ptr) - N'(1));
  assign req_hi  = req & ge_mask;
  assign cand    = (|req_hi) ? req_hi : req;
  assign pick    = cand & (~cand + N'(1));

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter letting several masters share one RAM slave,
// with a watchdog that terminates stalled cycles with an error.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
  output logic [DW-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam int SW = DW / 8;

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CW-1:0]          wd_cnt, wd_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [PW-1:0]          gidx;
  logic                   stb_raw, resp, stalled, timeout_hit;

  wb_arb_rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
    .req  (m_cyc_i),
    .ptr  (ptr_q),
    .pick (pick)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) gidx = PW'(i);
  end

  assign stb_raw     = |(grant_q & m_stb_i);
  assign resp        = s_ack_i | s_err_i | s_rty_i;
  assign stalled     = (state_q == ST_BUSY) && stb_raw && !resp;
  assign timeout_hit = (TIMEOUT != 0) && stalled && (wd_cnt == TO_LAST);
  assign m_dat_o     = s_dat_i;
  assign grant_o     = grant_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wd_cnt  <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wd_d    = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_cyc_o = 1'b1;
        s_stb_o = stb_raw && !timeout_hit;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_q[i]) begin
            s_adr_o = m_adr_i[i*AW +: AW];
            s_dat_o = m_dat_i[i*DW +: DW];
            s_sel_o = m_sel_i[i*SW +: SW];
            s_we_o  = m_we_i[i];
            s_cti_o = m_cti_i[i*3 +: 3];
            s_bte_o = m_bte_i[i*2 +: 2];
          end
        end
        m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
        m_err_o = grant_q & {NUM_MASTERS{s_err_i | timeout_hit}};
        m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
        if (stalled && !timeout_hit) wd_d = wd_cnt + CW'(1);
        // Terminations above still reach the master in its release cycle.
        if (!(|(grant_q & m_cyc_i))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_wb_mem_arbiter;
  import wb_mem_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*SW-1:0]   m_sel_i;
  logic [N-1:0]      m_we_i, m_cyc_i, m_stb_i;
  logic [N*3-1:0]    m_cti_i;
  logic [N*2-1:0]    m_bte_i;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]      grant_o;

  int checks = 0;
  int errors = 0;

  wb_mem_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .m_adr_i  (m_adr_i),  .m_dat_i  (m_dat_i),  .m_sel_i (m_sel_i),
    .m_we_i   (m_we_i),   .m_cyc_i  (m_cyc_i),  .m_stb_i (m_stb_i),
    .m_cti_i  (m_cti_i),  .m_bte_i  (m_bte_i),  .m_dat_o (m_dat_o),
    .m_ack_o  (m_ack_o),  .m_err_o  (m_err_o),  .m_rty_o (m_rty_o),
    .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o (s_sel_o),
    .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o (s_stb_o),
    .s_cti_o  (s_cti_o),  .s_bte_o  (s_bte_o),  .s_dat_i (s_dat_i),
    .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),  .s_rty_i (s_rty_i),
    .grant_o  (grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus, where the rotation resumes, and how
  // many consecutive strobe cycles have gone unanswered.
  bit mdl_busy  = 1'b0;
  int mdl_owner = 0;
  int mdl_ptr   = 0;
  int mdl_stall = 0;

  function automatic bit mdl_timeout();
    bit own_stb;
    own_stb = mdl_busy && (|((N'(1) << mdl_owner) & m_stb_i));
    return own_stb && !(s_ack_i || s_err_i || s_rty_i) && (TO > 0) && (mdl_stall == TO - 1);
  endfunction

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    bit to, found;
    if (wb_rst_i) begin
      mdl_busy = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_stall = 0;
    end else if (mdl_busy) begin
      to = mdl_timeout();
      if (!(|((N'(1) << mdl_owner) & m_cyc_i))) begin
        mdl_ptr   = (mdl_owner + 1) % N;
        mdl_busy  = 1'b0;
        mdl_stall = 0;
      end else if ((|((N'(1) << mdl_owner) & m_stb_i)) && !(s_ack_i || s_err_i || s_rty_i) && !to)
        mdl_stall = mdl_stall + 1;
      else
        mdl_stall = 0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mdl_ptr + k) % N;
        if (!found && (|((N'(1) << c) & m_cyc_i))) begin
          found = 1'b1; mdl_owner = c; mdl_busy = 1'b1;
        end
      end
      mdl_stall = 0;
    end
  end

  logic [N*AW-1:0] adr_sh;
  logic [N*DW-1:0] dat_sh;
  logic [N*SW-1:0] sel_sh;
  logic [N*3-1:0]  cti_sh;
  logic [N*2-1:0]  bte_sh;
  logic [N-1:0]    own_oh;
  logic [AW-1:0]   e_adr;
  logic [DW-1:0]   e_dat;
  logic [SW-1:0]   e_sel;
  logic [5:0]      e_ctl;
  bit              e_to;

  always @(negedge wb_clk_i) begin
    e_to   = mdl_timeout();
    own_oh = mdl_busy ? (N'(1) << mdl_owner) : '0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_ctl = '0;
    if (mdl_busy) begin
      adr_sh = m_adr_i >> (mdl_owner * AW);
      dat_sh = m_dat_i >> (mdl_owner * DW);
      sel_sh = m_sel_i >> (mdl_owner * SW);
      cti_sh = m_cti_i >> (mdl_owner * 3);
      bte_sh = m_bte_i >> (mdl_owner * 2);
      e_adr = adr_sh[AW-1:0];
      e_dat = dat_sh[DW-1:0];
      e_sel = sel_sh[SW-1:0];
      e_ctl = {|(own_oh & m_we_i), cti_sh[2:0], bte_sh[1:0]};
    end
    checkOutput("grant", grant_o, own_oh);
    checkOutput("s_cyc", s_cyc_o, mdl_busy);
    checkOutput("s_stb", s_stb_o, (|(own_oh & m_stb_i)) && !e_to);
    checkOutput("s_adr", s_adr_o, e_adr);
    checkOutput("s_dat", s_dat_o, e_dat);
    checkOutput("s_sel", s_sel_o, e_sel);
    checkOutput("s_ctl", {s_we_o, s_cti_o, s_bte_o}, e_ctl);
    checkOutput("m_ack", m_ack_o, own_oh & {N{s_ack_i}});
    checkOutput("m_err", m_err_o, own_oh & {N{s_err_i | e_to}});
    checkOutput("m_rty", m_rty_o, own_oh & {N{s_rty_i}});
    checkOutput("m_dat", m_dat_o, s_dat_i);
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] cyc, input logic ack);
    m_cyc_i = cyc;
    m_stb_i = cyc;
    m_adr_i = {$urandom(), $urandom(), $urandom()};
    m_dat_i = {$urandom(), $urandom(), $urandom()};
    m_sel_i = (N*SW)'($urandom());
    m_we_i  = N'($urandom());
    s_dat_i = $urandom();
    s_ack_i = ack;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
  endtask

  int order [4] = '{0, 1, 2, 0};
  int prev;

  initial begin
    m_cti_i = '0; m_bte_i = '0;
    applyStimulus('0, 1'b0);
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("reset_grant", grant_o, '0);
    checkOutput("reset_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    wb_rst_i = 1'b0;
    tick(); tick();

    // Simultaneous m0/m1 request right after reset.
    applyStimulus(3'b011, 1'b0);
    tick();
    checkOutput("r027_grant_m0", grant_o, 3'b001);
    applyStimulus(3'b011, 1'b1);
    tick();
    applyStimulus(3'b010, 1'b0);
    tick();
    checkOutput("r027_idle_gap", {grant_o, s_cyc_o}, 4'b0000);
    tick();
    checkOutput("r027_grant_m1", grant_o, 3'b010);

    // m0 four-beat burst while m2 waits.
    applyStimulus(3'b000, 1'b0);
    tick();
    applyStimulus(3'b001, 1'b0);
    tick();
    checkOutput("r028_grant_m0", grant_o, 3'b001);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(3'b101, 1'b1);
      m_cti_i[2:0] = (b < 3) ? CTI_INCR : CTI_END;
      #1;
      checkOutput("r028_ack_beat", m_ack_o, 3'b001);
      tick();
      checkOutput("r028_hold", grant_o, 3'b001);
    end
    m_cti_i = '0;
    applyStimulus(3'b100, 1'b0);
    tick();
    checkOutput("r028_release", grant_o, 3'b000);
    tick();
    checkOutput("r028_grant_m2", grant_o, 3'b100);

    // Everyone keeps requesting; pointer must wrap m0, m1, m2, m0.
    prev = 2;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b111 & ~(N'(1) << prev), 1'b0);
      tick();
      applyStimulus(3'b111, 1'b0);
      tick();
      checkOutput("r029_order", grant_o, N'(1) << order[k]);
      prev = order[k];
    end

    // m1 stalls with no slave answer: error on the 4th stalled cycle.
    applyStimulus(3'b000, 1'b0);
    tick();
    applyStimulus(3'b010, 1'b0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      checkOutput("r030_err", m_err_o, (c == 4) ? 3'b010 : 3'b000);
      checkOutput("r030_others", {m_ack_o, m_rty_o, m_err_o & 3'b101}, '0);
      if (c == 4) checkOutput("r030_stb_low", s_stb_o, 1'b0);
      else tick();
    end
    tick();
    checkOutput("r030_recover", {m_err_o, s_stb_o}, 4'b0001);

    // Reset in the middle of an m1 burst.
    applyStimulus(3'b010, 1'b1);
    m_cti_i[5:3] = CTI_INCR;
    tick();
    #2 wb_rst_i = 1'b1;
    #1;
    checkOutput("r031_cyc", s_cyc_o, 1'b0);
    checkOutput("r031_grant", grant_o, 3'b000);
    checkOutput("r031_noterm", {m_ack_o, m_err_o, m_rty_o}, '0);
    @(negedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    m_cti_i = '0;
    applyStimulus(3'b011, 1'b0);
    tick();
    checkOutput("r031_m0_first", grant_o, 3'b001);

    // Ack arriving in the same cycle m0 drops cyc.
    applyStimulus(3'b010, 1'b1);
    #1;
    checkOutput("r032_ack_on_drop", m_ack_o, 3'b001);
    tick();
    checkOutput("r032_idle", {grant_o, s_cyc_o}, 4'b0000);
    applyStimulus(3'b011, 1'b0);
    tick();
    checkOutput("r032_ptr1", grant_o, 3'b010);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] cyc;
      cyc = m_cyc_i;
      for (int m = 0; m < N; m++)
        if ($urandom_range(0, 3) == 0) cyc = cyc ^ (N'(1) << m);
      applyStimulus(cyc, $urandom_range(0, 2) == 0);
      m_stb_i = cyc & N'($urandom());
      m_cti_i = (N*3)'($urandom());
      m_bte_i = (N*2)'($urandom());
      s_err_i = ($urandom_range(0, 15) == 0);
      s_rty_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 wb_rst_i = 1'b1;
        #4 wb_rst_i = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
